fp_addsub_presort: RTL and testbench

FP_ADDSUB_PRESORT -- requirements
Module: fp_addsub_presort

---
 rtl/fp_addsub_presort.sv | 149 ++++++++++++++
 tb/tb_fp_addsub_presort.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_presort.sv
// Front end of an FP adder: orders operands by magnitude, aligns exponents and
// resolves the result sign, in a two-stage valid/ready pipeline.
module fp_addsub_presort #(
  parameter int EW  = 8,
  parameter int MW  = 23,
  parameter int SAT = MW + 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          op,
  input  logic [1:0]    rm,
  input  logic          a_s,
  input  logic          b_s,
  input  logic [EW-1:0] a_e,
  input  logic [EW-1:0] b_e,
  input  logic [MW-1:0] a_m,
  input  logic [MW-1:0] b_m,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] big_e,
  output logic [MW:0]   big_m,
  output logic [MW:0]   small_m,
  output logic [EW-1:0] exp_diff,
  output logic          eff_sub,
  output logic          sign,
  output logic          swap,
  output logic          equal,
  output logic          nan_in,
  output logic [1:0]    rm_q
);
  localparam logic [EW-1:0] SAT_V = EW'(SAT);
  localparam logic [1:0]    RM_RDN = 2'b10;

  // stage 1
  logic          s1_vld_q, s1_a_s_q, s1_b_eff_q, s1_eff_sub_q, s1_swap_q, s1_equal_q;
  logic [1:0]    s1_rm_q;
  logic [EW-1:0] s1_a_e_q, s1_b_e_q;
  logic [MW-1:0] s1_a_m_q, s1_b_m_q;
  // stage 2
  logic          s2_vld_q, sign_q, swap_q, equal_q, eff_sub_q, nan_q;
  logic [1:0]    rm2_q;
  logic [EW-1:0] big_e_q, diff_q;
  logic [MW:0]   big_m_q, small_m_q;

  logic s1_load, s2_load;
  logic b_eff_d;
  logic [EW+MW-1:0] mag_a, mag_b;

  // Stage 1 advances into stage 2 whenever stage 2 is free or draining.
  assign s2_load  = s1_vld_q & (~s2_vld_q | out_ready);
  assign in_ready = ~s1_vld_q | s2_load;
  assign s1_load  = in_valid & in_ready;

  assign b_eff_d = b_s ^ op;
  assign mag_a   = {a_e, a_m};
  assign mag_b   = {b_e, b_m};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      s1_a_s_q     <= 1'b0;
      s1_b_eff_q   <= 1'b0;
      s1_eff_sub_q <= 1'b0;
      s1_swap_q    <= 1'b0;
      s1_equal_q   <= 1'b0;
      s1_rm_q      <= '0;
      s1_a_e_q     <= '0;
      s1_b_e_q     <= '0;
      s1_a_m_q     <= '0;
      s1_b_m_q     <= '0;
    end else begin
      if (s1_load || s2_load) s1_vld_q <= s1_load;
      if (s1_load) begin
        s1_a_s_q     <= a_s;
        s1_b_eff_q   <= b_eff_d;
        s1_eff_sub_q <= a_s ^ b_eff_d;
        s1_swap_q    <= mag_b > mag_a;
        s1_equal_q   <= mag_a == mag_b;
        s1_rm_q      <= rm;
        s1_a_e_q     <= a_e;
        s1_b_e_q     <= b_e;
        s1_a_m_q     <= a_m;
        s1_b_m_q     <= b_m;
      end
    end
  end

  // Stage 2 combinational routing: A stays big on ties.
  logic [EW-1:0] big_e_d, small_e_d, raw_diff_d, diff_d;
  logic [MW:0]   big_m_d, small_m_d;
  logic          sign_d, nan_d;

  always_comb begin
    big_e_d   = s1_swap_q ? s1_b_e_q : s1_a_e_q;
    small_e_d = s1_swap_q ? s1_a_e_q : s1_b_e_q;
    big_m_d   = s1_swap_q ? {|s1_b_e_q, s1_b_m_q} : {|s1_a_e_q, s1_a_m_q};
    small_m_d = s1_swap_q ? {|s1_a_e_q, s1_a_m_q} : {|s1_b_e_q, s1_b_m_q};
    raw_diff_d = big_e_d - small_e_d;
    diff_d     = (raw_diff_d > SAT_V) ? SAT_V : raw_diff_d;
    if (!s1_equal_q)       sign_d = s1_swap_q ? s1_b_eff_q : s1_a_s_q;
    else if (!s1_eff_sub_q) sign_d = s1_a_s_q;
    else                   sign_d = (s1_rm_q == RM_RDN);
    nan_d = ((&s1_a_e_q) & (|s1_a_m_q)) | ((&s1_b_e_q) & (|s1_b_m_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q  <= 1'b0;
      sign_q    <= 1'b0;
      swap_q    <= 1'b0;
      equal_q   <= 1'b0;
      eff_sub_q <= 1'b0;
      nan_q     <= 1'b0;
      rm2_q     <= '0;
      big_e_q   <= '0;
      diff_q    <= '0;
      big_m_q   <= '0;
      small_m_q <= '0;
    end else begin
      if (s2_load || out_ready) s2_vld_q <= s2_load;
      if (s2_load) begin
        sign_q    <= sign_d;
        swap_q    <= s1_swap_q;
        equal_q   <= s1_equal_q;
        eff_sub_q <= s1_eff_sub_q;
        nan_q     <= nan_d;
        rm2_q     <= s1_rm_q;
        big_e_q   <= big_e_d;
        diff_q    <= diff_d;
        big_m_q   <= big_m_d;
        small_m_q <= small_m_d;
      end
    end
  end

  assign out_valid = s2_vld_q;
  assign big_e     = big_e_q;
  assign big_m     = big_m_q;
  assign small_m   = small_m_q;
  assign exp_diff  = diff_q;
  assign eff_sub   = eff_sub_q;
  assign sign      = sign_q;
  assign swap      = swap_q;
  assign equal     = equal_q;
  assign nan_in    = nan_q;
  assign rm_q      = rm2_q;
endmodule

// File: tb/tb_fp_addsub_presort.sv
// Scoreboard bench for fp_addsub_presort at default parameters.
module tb_fp_addsub_presort;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, op = 0, a_s = 0, b_s = 0;
  logic [1:0] rm = 0, rm_q;
  logic [7:0] a_e = 0, b_e = 0, big_e, exp_diff;
  logic [22:0] a_m = 0, b_m = 0;
  logic out_valid, out_ready = 1, eff_sub, sign, swap, equal, nan_in;
  logic [23:0] big_m, small_m;

  fp_addsub_presort dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .rm(rm),
    .a_s(a_s), .b_s(b_s), .a_e(a_e), .b_e(b_e), .a_m(a_m), .b_m(b_m),
    .out_valid(out_valid), .out_ready(out_ready), .big_e(big_e), .big_m(big_m),
    .small_m(small_m), .exp_diff(exp_diff), .eff_sub(eff_sub), .sign(sign), .swap(swap),
    .equal(equal), .nan_in(nan_in), .rm_q(rm_q));

  always #5 clk = ~clk;

  typedef struct packed {
    logic sign, swap, equal, eff_sub, nan_in;
    logic [1:0] rm;
    logic [7:0] be;
    logic [23:0] bm, sm;
    logic [7:0] ed;
  } res_t;
  typedef struct { res_t r; int cyc; } ent_t;

  ent_t sb[$];
  ent_t e;
  res_t got, held;
  bit held_v = 0, chk_lat = 0;
  int nchk = 0, nerr = 0, cyc = 0;

  assign got = {sign, swap, equal, eff_sub, nan_in, rm_q, big_e, big_m, small_m, exp_diff};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic res_t model(input logic o, input logic [1:0] r, input logic as, input logic [7:0] ae,
                                 input logic [22:0] am, input logic bs, input logic [7:0] be, input logic [22:0] bm);
    res_t x;
    logic beff, esub;
    int ma, mb, d;
    beff = bs ^ o;
    esub = as ^ beff;
    ma = int'(ae) * (1 << 23) + int'(am);
    mb = int'(be) * (1 << 23) + int'(bm);
    x = '0;
    x.swap = mb > ma;
    x.equal = ma == mb;
    x.eff_sub = esub;
    x.rm = r;
    x.nan_in = (ae == 8'hff && am != 0) || (be == 8'hff && bm != 0);
    if (x.swap) begin
      x.be = be; x.bm = {be != 0, bm}; x.sm = {ae != 0, am}; d = int'(be) - int'(ae);
    end else begin
      x.be = ae; x.bm = {ae != 0, am}; x.sm = {be != 0, bm}; d = int'(ae) - int'(be);
    end
    x.ed = (d > 26) ? 8'd26 : 8'(d);
    if (x.equal) x.sign = esub ? (r == 2'b10) : as;
    else         x.sign = x.swap ? beff : as;
    return x;
  endfunction

  // Monitor: occupancy, stall stability, in-order results, acceptance capture.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      held_v = 0;
    end else begin
      chk("in_ready", in_ready, (sb.size() < 2) || out_ready);
      if (held_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", got, held);
      end
      held_v = out_valid && !out_ready;
      held = got;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = sb.pop_front();
          chk("result", got, e.r);
          if (chk_lat) chk("latency", cyc - e.cyc, 2);
        end
      end
      if (in_valid && in_ready) begin
        e.r = model(op, rm, a_s, a_e, a_m, b_s, b_e, b_m);
        e.cyc = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic o, input logic [1:0] r, input logic as, input logic [7:0] ae,
                      input logic [22:0] am, input logic bs, input logic [7:0] be, input logic [22:0] bm);
    bit ok;
    op = o; rm = r; a_s = as; a_e = ae; a_m = am; b_s = bs; b_e = be; b_m = bm;
    in_valid = 1;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_rand();
    logic [7:0] ae, be;
    logic [22:0] am, bm;
    ae = 8'($urandom_range(0, 255)); be = 8'($urandom_range(0, 255));
    am = 23'($urandom); bm = 23'($urandom);
    case ($urandom_range(0, 4))
      0: begin be = ae; bm = am; end
      1: ae = 8'h00;
      2: be = 8'hff;
      default: ;
    endcase
    send(1'($urandom), 2'($urandom), 1'($urandom), ae, am, 1'($urandom), be, bm);
  endtask

  task automatic idle();
    in_valid = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data", got, '0);
    rst = 0;
    @(posedge clk); #1;

    // directed, no backpressure
    chk_lat = 1;
    send(0, 2'b00, 0, 8'd127, 23'h400000, 0, 8'd128, 23'h0);   // 1.5 + 2.0
    send(1, 2'b10, 0, 8'd128, 23'h400000, 0, 8'd128, 23'h400000); // 3 - 3, RDN
    send(1, 2'b00, 0, 8'd128, 23'h400000, 0, 8'd128, 23'h400000); // 3 - 3, RNE
    send(0, 2'b00, 1, 8'd129, 23'h200000, 0, 8'd127, 23'h0);   // -5 + 1
    send(0, 2'b01, 0, 8'd200, 23'h1, 1, 8'd10, 23'h7);         // saturated diff
    send(0, 2'b11, 0, 8'd3, 23'h5, 0, 8'd0, 23'h123);          // B denormal
    send(1, 2'b00, 1, 8'hff, 23'h1, 0, 8'd5, 23'h0);           // NaN A
    send(0, 2'b00, 0, 8'd0, 23'h0, 1, 8'd0, 23'h0);            // +0 + -0
    idle();
    drain();

    // back-to-back stream with out_ready pattern 1,0,0,1
    chk_lat = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
        idle();
      end
      begin
        for (int k = 0; k < 40; k++) begin
          out_ready = pat[k % 4];
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    drain();

    // random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          send_rand();
          if ($urandom_range(0, 3) == 0) begin idle(); @(posedge clk); #1; end
        end
        idle();
      end
      begin
        for (int k = 0; k < 80; k++) begin
          out_ready = 1'($urandom);
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    drain();

    // reset with two transactions in flight
    out_ready = 1;
    send(0, 2'b00, 0, 8'd50, 23'h10, 0, 8'd60, 23'h20);
    send(1, 2'b01, 1, 8'd70, 23'h30, 0, 8'd40, 23'h40);
    idle();
    rst = 1;
    @(posedge clk); #1;
    chk("rst_flush_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (4) @(posedge clk);
    #1;
    chk_lat = 1;
    send(0, 2'b11, 0, 8'd90, 23'h55, 1, 8'd90, 23'h56);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
